// File: rtl/bram_capture_ctrl_pkg.sv
// Shared types and defaults for the BRAM capture controller.
// State encodings are fixed because o_state exposes them directly.
package bram_capture_ctrl_pkg;

  localparam int NB_ADDR_DEF = 15;
  localparam int NB_DATA_DEF = 14;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_FULL    = 2'd2,
    ST_DUMP    = 2'd3
  } state_e;

endpackage

// File: rtl/bram_capture_ctrl_if.sv
// Capture/readout bus between the controller and its user.
// master drives requests and samples; slave is the controller.
interface bram_capture_ctrl_if
  import bram_capture_ctrl_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF
);

  logic               i_start;
  logic               i_read_start;
  logic [NB_DATA-1:0] i_data;
  logic               i_valid;
  logic [NB_DATA-1:0] o_data;
  logic               o_valid;
  logic               o_last;
  logic               o_full;
  logic               o_busy;
  logic [1:0]         o_state;

  modport master (
    output i_start, i_read_start, i_data, i_valid,
    input  o_data, o_valid, o_last, o_full, o_busy, o_state
  );

  modport slave (
    input  i_start, i_read_start, i_data, i_valid,
    output o_data, o_valid, o_last, o_full, o_busy, o_state
  );

endinterface

// File: rtl/bram_capture_ctrl_bram.sv
// Simple dual-port block RAM: one write port, one registered read port.
// Read data only updates on a read enable, so it holds between reads.
module bram_capture_ctrl_bram #(
  parameter int NB_ADDR = 15,
  parameter int NB_DATA = 14
) (
  input  logic               clk_i,
  input  logic               we_i,
  input  logic [NB_ADDR-1:0] waddr_i,
  input  logic [NB_DATA-1:0] wdata_i,
  input  logic               re_i,
  input  logic [NB_ADDR-1:0] raddr_i,
  output logic [NB_DATA-1:0] rdata_o
);

  logic [NB_DATA-1:0] mem_q [2**NB_ADDR];
  logic [NB_DATA-1:0] rdata_q;

  // write port
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // registered read port
  always_ff @(posedge clk_i) begin
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/bram_capture_ctrl.sv
// Capture a block of samples into BRAM, then stream it back out.
// Counters carry one extra bit so the terminal compare never aliases.
module bram_capture_ctrl
  import bram_capture_ctrl_pkg::*;
#(
  parameter int NB_ADDR = NB_ADDR_DEF,
  parameter int NB_DATA = NB_DATA_DEF
) (
  input  logic                clock,
  input  logic                i_reset_n,
  bram_capture_ctrl_if.slave  bus
);

  localparam logic [NB_ADDR:0] LAST = {1'b0, {NB_ADDR{1'b1}}};
  localparam logic [NB_ADDR:0] ONE  = {{NB_ADDR{1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [NB_ADDR:0] wr_q, wr_d;
  logic [NB_ADDR:0] rd_q, rd_d;
  logic             we, re;
  logic             valid_q, last_q;

  // next state, counters and RAM enables
  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    we      = 1'b0;
    re      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.i_start) begin
          state_d = ST_CAPTURE;
          wr_d    = '0;
        end
      end
      ST_CAPTURE: begin
        if (bus.i_valid) begin
          we   = 1'b1;
          wr_d = wr_q + ONE;
          if (wr_q == LAST) state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (bus.i_read_start) begin
          state_d = ST_DUMP;
          rd_d    = '0;
        end else if (bus.i_start) begin
          state_d = ST_CAPTURE;
          wr_d    = '0;
        end
      end
      ST_DUMP: begin
        re   = 1'b1;
        rd_d = rd_q + ONE;
        if (rd_q == LAST) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // state, counters and the read-valid pipeline stage
  always_ff @(posedge clock) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
      wr_q    <= '0;
      rd_q    <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      valid_q <= re;
      last_q  <= re && (rd_q == LAST);
    end
  end

  bram_capture_ctrl_bram #(
    .NB_ADDR (NB_ADDR),
    .NB_DATA (NB_DATA)
  ) u_bram (
    .clk_i   (clock),
    .we_i    (we & i_reset_n),
    .waddr_i (wr_q[NB_ADDR-1:0]),
    .wdata_i (bus.i_data),
    .re_i    (re & i_reset_n),
    .raddr_i (rd_q[NB_ADDR-1:0]),
    .rdata_o (bus.o_data)
  );

  assign bus.o_valid = valid_q;
  assign bus.o_last  = last_q;
  assign bus.o_full  = (state_q == ST_FULL);
  assign bus.o_busy  = (state_q == ST_CAPTURE) || (state_q == ST_DUMP);
  assign bus.o_state = state_q;

endmodule

// File: tb/tb_bram_capture_ctrl.sv
// Bench for bram_capture_ctrl with DEPTH=8.
// Dump words are checked by a monitor against a scoreboard queue.
module tb_bram_capture_ctrl;

  localparam int NA    = 3;
  localparam int ND    = 14;
  localparam int DEPTH = 8;

  logic clock = 1'b0;
  logic rst_n = 1'b0;

  always #5 clock = ~clock;

  bram_capture_ctrl_if #(.NB_DATA(ND)) bus ();

  bram_capture_ctrl #(
    .NB_ADDR (NA),
    .NB_DATA (ND)
  ) dut (
    .clock     (clock),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  int total = 0;
  int bad   = 0;
  int seen  = 0;

  logic [ND:0]   exp_q [$];
  logic [ND-1:0] model [DEPTH];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, want);
    end
  endtask

  // monitor: every presented word is popped and compared
  always @(negedge clock) begin : mon
    logic [ND:0] e;
    if (bus.o_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_word: got %0h expected none",
                 bus.o_data);
      end else begin
        e = exp_q.pop_front();
        chk("dump_data", 32'(bus.o_data), 32'(e[ND-1:0]));
        chk("dump_last", 32'(bus.o_last), 32'(e[ND]));
      end
      seen++;
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic capture(input logic [ND-1:0] base, input bit toggle);
    int k;
    k = 0;
    bus.i_start = 1'b1;
    cyc();
    bus.i_start = 1'b0;
    chk("cap_state", 32'(bus.o_state), 1);
    chk("cap_busy", 32'(bus.o_busy), 1);
    chk("cap_full", 32'(bus.o_full), 0);
    for (int c = 0; c < (toggle ? 16 : 8); c++) begin
      if (toggle && (c % 2 == 1)) begin
        bus.i_valid      = 1'b0;
        bus.i_data       = ND'(14'h3F00 + c);
        bus.i_start      = (c == 5);
        bus.i_read_start = (c == 7);
      end else begin
        bus.i_valid      = 1'b1;
        bus.i_data       = base + ND'(k);
        bus.i_start      = 1'b0;
        bus.i_read_start = 1'b0;
        model[k]         = base + ND'(k);
        k++;
      end
      cyc();
    end
    bus.i_valid      = 1'b0;
    bus.i_start      = 1'b0;
    bus.i_read_start = 1'b0;
    chk("full_state", 32'(bus.o_state), 2);
    chk("full_flag", 32'(bus.o_full), 1);
    chk("full_busy", 32'(bus.o_busy), 0);
  endtask

  task automatic launch(input bit both, output int target);
    for (int i = 0; i < DEPTH; i++)
      exp_q.push_back({(i == DEPTH - 1), model[i]});
    target = seen + DEPTH;
    bus.i_read_start = 1'b1;
    bus.i_start      = both;
    cyc();
    bus.i_read_start = 1'b0;
    bus.i_start      = 1'b0;
    chk("dump_state", 32'(bus.o_state), 3);
    chk("dump_busy", 32'(bus.o_busy), 1);
    chk("dump_full", 32'(bus.o_full), 0);
    chk("dump_lat1", 32'(bus.o_valid), 0);
    cyc();
    chk("dump_lat2", 32'(bus.o_valid), 1);
  endtask

  task automatic wait_seen(input int target);
    int n;
    n = 0;
    while (seen < target && n < 50) begin
      @(negedge clock);
      #1;
      n++;
    end
    chk("words_seen", 32'(seen), 32'(target));
  endtask

  task automatic run_dump(input bit both);
    int t;
    launch(both, t);
    wait_seen(t);
    cyc();
    chk("end_state", 32'(bus.o_state), 0);
    chk("end_valid", 32'(bus.o_valid), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int t;
    bus.i_start      = 1'b0;
    bus.i_read_start = 1'b0;
    bus.i_data       = '0;
    bus.i_valid      = 1'b0;
    rst_n = 1'b0;
    repeat (3) cyc();
    chk("rst_state", 32'(bus.o_state), 0);
    chk("rst_valid", 32'(bus.o_valid), 0);
    chk("rst_last", 32'(bus.o_last), 0);
    chk("rst_full", 32'(bus.o_full), 0);
    chk("rst_busy", 32'(bus.o_busy), 0);
    rst_n = 1'b1;

    bus.i_read_start = 1'b1;
    cyc();
    bus.i_read_start = 1'b0;
    chk("idle_ignore", 32'(bus.o_state), 0);
    cyc();
    chk("idle_novalid", 32'(bus.o_valid), 0);

    capture(14'h10, 1'b0);
    run_dump(1'b0);

    capture(14'h40, 1'b1);
    run_dump(1'b0);

    capture(14'h50, 1'b0);
    run_dump(1'b1);

    capture(14'h60, 1'b0);
    capture(14'h20, 1'b0);
    run_dump(1'b0);

    capture(14'h70, 1'b0);
    launch(1'b0, t);
    wait_seen(t - DEPTH + 4);
    rst_n = 1'b0;
    cyc();
    chk("abort_valid", 32'(bus.o_valid), 0);
    chk("abort_state", 32'(bus.o_state), 0);
    chk("abort_busy", 32'(bus.o_busy), 0);
    chk("abort_full", 32'(bus.o_full), 0);
    exp_q.delete();
    cyc();
    rst_n = 1'b1;
    repeat (4) cyc();
    chk("abort_words", 32'(seen), 32'(t - DEPTH + 4));

    capture(14'h30, 1'b0);
    run_dump(1'b0);

    repeat (3) cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bram_capture_ctrl.md
BRAM_CAPTURE_CTRL -- requirements
Module: bram_capture_ctrl

Interface
REQ-001 Parameter NB_ADDR, default 15, address width; DEPTH = 2**NB_ADDR words.
REQ-002 Parameter NB_DATA, default 14, sample/word width.
REQ-003 The block SHALL have one clock and a synchronous, active-low reset.
REQ-004 clock  input  1  rising-edge system clock.
REQ-005 i_reset_n  input  1  synchronous, active-low reset.
REQ-006 i_start  input  1  single-cycle pulse requesting a capture.
REQ-007 i_read_start  input  1  single-cycle pulse requesting a readout.
REQ-008 i_data  input  NB_DATA  capture sample.
REQ-009 i_valid  input  1  i_data qualifier.
REQ-010 o_data  output  NB_DATA  readout word.
REQ-011 o_valid  output  1  o_data qualifier.
REQ-012 o_last  output  1  marks the final readout word.
REQ-013 o_full  output  1  memory holds a complete capture.
REQ-014 o_busy  output  1  high in CAPTURE or DUMP.
REQ-015 o_state  output  2  current FSM state encoding.

Function
REQ-016 The FSM SHALL have four states: IDLE=0, CAPTURE=1, FULL=2, DUMP=3.
REQ-017 IDLE: i_start -> CAPTURE with write address 0; i_read_start ignored.
REQ-018 CAPTURE: each cycle with i_valid=1 SHALL write i_data to the current write address, then increment it; cycles with i_valid=0 write nothing and hold the address.
REQ-019 CAPTURE: the write at address DEPTH-1 SHALL transition to FULL on the next edge; no wrap and no further writes.
REQ-020 CAPTURE: i_start and i_read_start SHALL be ignored.
REQ-021 FULL: o_full=1; i_read_start -> DUMP with read address 0; i_start -> CAPTURE with write address 0 (overwrite).
REQ-022 FULL: if i_start and i_read_start arrive in the same cycle, i_read_start SHALL win.
REQ-023 DUMP: read enable SHALL be asserted every cycle, with the read address incrementing from 0 to DEPTH-1.
REQ-024 DUMP: after issuing address DEPTH-1, the FSM SHALL go to IDLE; all inputs are ignored during DUMP.
REQ-025 Read latency SHALL be 1 cycle: o_valid is the read enable delayed one cycle, giving exactly DEPTH consecutive o_valid cycles per dump.
REQ-026 o_last SHALL be high together with o_valid for the word read from address DEPTH-1 only.
REQ-027 Address counters SHALL be NB_ADDR+1 bits wide so that terminal detection does not alias at wrap-around.
REQ-028 o_data SHALL hold its last value when o_valid=0.
REQ-029 o_full SHALL clear when leaving FULL, in either direction.

Reset
REQ-030 While i_reset_n=0 at a clock edge, the block SHALL go to IDLE and clear both counters.
REQ-031 Under reset, o_valid, o_last, o_full and o_busy SHALL be 0 and o_state SHALL be 0.
REQ-032 o_data is undefined until the first read.
REQ-033 Reset mid-CAPTURE or mid-DUMP SHALL abort the operation with no further writes or o_valid pulses; memory contents are not cleared.
REQ-034 The o_valid pipeline stage SHALL also be reset, so no stray word appears after reset.

Structure
REQ-035 A shared package SHALL hold the state encodings (IDLE/CAPTURE/FULL/DUMP) and default NB_ADDR/NB_DATA constants.
REQ-036 The block SHALL contain exactly one sub-module: the dual-port block RAM bram.
REQ-037 bram SHALL have a registered read, a write-enable and a read-enable; the controller drives its write address, read address and enables.
REQ-038 Next-state logic SHALL be combinational, with a single registered state register.

Verification (NB_ADDR=3, DEPTH=8)
REQ-039 Reset, then i_start, then 8 valid samples 0x10..0x17 -> o_full=1 and o_state=2 one cycle after the 8th write.
REQ-040 In FULL, pulse i_read_start -> o_valid high for exactly 8 cycles starting 2 cycles after the pulse, o_data 0x10..0x17, o_last only on 0x17, then o_state=0.
REQ-041 In CAPTURE, toggle i_valid 1/0 for 16 cycles -> only the 8 valid samples are stored, in order, verified by a subsequent dump.
REQ-042 In FULL, pulse i_start and i_read_start in the same cycle -> DUMP entered; contents unchanged.
REQ-043 Assert i_reset_n=0 after 4 dump words -> o_valid=0 from the next edge; o_state=0; a new capture and dump then works correctly.
REQ-044 In FULL, pulse i_start, then write 0x20..0x27 -> the dump returns 0x20..0x27 (overwrite verified).
